// File: rtl/game_keys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_keys_pkg
//  Description : Keyboard key codes, direction encodings, hold-FSM state
//                type and decode helpers. Also used by the game display logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_keys_pkg;

    // Lowercase ASCII codes of the mapped keys
    localparam logic [7:0] KEY_W = 8'h77;
    localparam logic [7:0] KEY_A = 8'h61;
    localparam logic [7:0] KEY_S = 8'h73;
    localparam logic [7:0] KEY_D = 8'h64;
    localparam logic [7:0] KEY_P = 8'h70;
    localparam logic [7:0] KEY_R = 8'h72;

    // One-hot direction encoding {up,down,left,right}
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    // Hold-FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = ST_IDLE,
        S_HELD = ST_HELD
    } hold_state_t;

    // Fold 'A'..'Z' onto 'a'..'z'; every other byte passes unchanged
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        if ((b >= 8'h41) && (b <= 8'h5A)) begin
            return b | 8'h20;
        end
        return b;
    endfunction

    // Map a lowercase key code to its direction; DIR_NONE if not a direction
    function automatic logic [3:0] key_to_dir(input logic [7:0] k);
        case (k)
            KEY_W:   return DIR_UP;
            KEY_S:   return DIR_DOWN;
            KEY_A:   return DIR_LEFT;
            KEY_D:   return DIR_RIGHT;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hold_timer
//  Description : Loadable down-counter that saturates at zero. Load value is
//                the COUNT parameter; clear forces zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int unsigned COUNT = 50,
    parameter int unsigned WIDTH = $clog2(COUNT + 1)
) (
    input  logic clk,
    input  logic rst,       // asynchronous, active low
    input  logic i_load,
    input  logic i_clear,
    output logic o_zero,
    output logic o_last
);

    localparam logic [WIDTH-1:0] c_LOAD = WIDTH'(COUNT);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Clear beats load; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_zero = (r_count == '0);
    // The next decrement reaches zero
    assign o_last = (r_count == c_ONE);

endmodule
`default_nettype wire

// File: rtl/uart_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_key_decoder
//  Description : Turns the UART keyboard byte stream into held direction
//                levels (surviving auto-repeat gaps), a pause level and
//                one-cycle restart / unmapped-key pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_key_decoder
    import game_keys_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned HOLD_MS = 600
) (
    input  logic       clk,
    input  logic       rst,      // asynchronous, active low
    input  logic       rxDone,
    input  logic [7:0] rxByte,
    output logic [3:0] dir,
    output logic [7:0] key_out,
    output logic       paused,
    output logic       restart,
    output logic       bad_key
);

    localparam int unsigned HOLD_CYCLES = (CLK_HZ / 1000) * HOLD_MS;
    localparam int unsigned c_TMR_W     = $clog2(HOLD_CYCLES + 1);

    hold_state_t r_state;
    logic [3:0]  r_dir;
    logic [7:0]  r_key;
    logic        r_paused;
    logic        r_restart;
    logic        r_bad;

    hold_state_t w_state;
    logic [3:0]  w_dir;
    logic [7:0]  w_key;
    logic        w_paused;
    logic        w_restart;
    logic        w_bad;
    logic        w_tmr_load;
    logic        w_tmr_clear;
    logic        w_tmr_zero;
    logic        w_tmr_last;

    logic [7:0]  w_byte;
    logic [3:0]  w_dir_code;
    logic        w_is_dir;
    logic        w_expire;

    hold_timer #(
        .COUNT (HOLD_CYCLES),
        .WIDTH (c_TMR_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_clear (w_tmr_clear),
        .o_zero  (w_tmr_zero),
        .o_last  (w_tmr_last)
    );

    // Byte decode and next-state logic; a direction byte overrides expiry
    always_comb begin
        w_byte      = fold_case(rxByte);
        w_dir_code  = key_to_dir(w_byte);
        w_is_dir    = (w_dir_code != DIR_NONE);
        w_expire    = (r_state == S_HELD) && (w_tmr_last || w_tmr_zero);

        w_state     = r_state;
        w_dir       = r_dir;
        w_key       = r_key;
        w_paused    = r_paused;
        w_restart   = 1'b0;
        w_bad       = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_clear = 1'b0;

        if (w_expire) begin
            w_state = S_IDLE;
            w_dir   = DIR_NONE;
            w_key   = 8'h00;
        end

        if (rxDone) begin
            if (w_is_dir) begin
                // Directions are silently dropped while paused
                if (!r_paused) begin
                    w_state    = S_HELD;
                    w_dir      = w_dir_code;
                    w_key      = w_byte;
                    w_tmr_load = 1'b1;
                end
            end else if (w_byte == KEY_P) begin
                w_paused    = ~r_paused;
                w_state     = S_IDLE;
                w_dir       = DIR_NONE;
                w_key       = 8'h00;
                w_tmr_clear = 1'b1;
            end else if (w_byte == KEY_R) begin
                w_restart   = 1'b1;
                w_paused    = 1'b0;
                w_state     = S_IDLE;
                w_dir       = DIR_NONE;
                w_key       = 8'h00;
                w_tmr_clear = 1'b1;
            end else begin
                w_bad = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_dir     <= DIR_NONE;
            r_key     <= 8'h00;
            r_paused  <= 1'b0;
            r_restart <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_dir     <= w_dir;
            r_key     <= w_key;
            r_paused  <= w_paused;
            r_restart <= w_restart;
            r_bad     <= w_bad;
        end
    end

    assign dir     = r_dir;
    assign key_out = r_key;
    assign paused  = r_paused;
    assign restart = r_restart;
    assign bad_key = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_uart_key_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_key_decoder
//  Description : Self-checking bench for uart_key_decoder, HOLD_CYCLES = 50.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_key_decoder;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       rxDone = 1'b0;
    logic [7:0] rxByte = 8'h00;
    logic [3:0] dir;
    logic [7:0] key_out;
    logic       paused;
    logic       restart;
    logic       bad_key;

    int n_tests = 0;
    int n_fail  = 0;

    uart_key_decoder #(
        .CLK_HZ  (10_000),
        .HOLD_MS (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxDone  (rxDone),
        .rxByte  (rxByte),
        .dir     (dir),
        .key_out (key_out),
        .paused  (paused),
        .restart (restart),
        .bad_key (bad_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] b;
        logic [3:0] d;
        logic [7:0] k;
        logic       p;
        logic       rs;
        logic       bk;
    } vec_t;

    vec_t sbq[$];
    vec_t tbl[16];

    function automatic vec_t mk(input int id, input logic [7:0] b, input logic [3:0] d,
                                input logic [7:0] k, input logic p, input logic rs,
                                input logic bk);
        vec_t v;
        v.id = id; v.b = b; v.d = d; v.k = k; v.p = p; v.rs = rs; v.bk = bk;
        return v;
    endfunction

    task automatic cmp(input string nm, input vec_t e);
        n_tests++;
        if (dir !== e.d || key_out !== e.k || paused !== e.p ||
            restart !== e.rs || bad_key !== e.bk) begin
            n_fail++;
            $display("FAIL %s: got dir=%b key=%h paused=%b restart=%b bad=%b, expected dir=%b key=%h paused=%b restart=%b bad=%b",
                     nm, dir, key_out, paused, restart, bad_key, e.d, e.k, e.p, e.rs, e.bk);
        end
    endtask

    // Scoreboard: every sampled strobe pops the expectation pushed by send()
    always @(posedge clk) begin : sb_check
        vec_t e;
        if (rxDone === 1'b1) begin
            #1;
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got strobe, expected empty queue entry");
            end else begin
                e = sbq.pop_front();
                cmp($sformatf("sb_id%0d", e.id), e);
            end
        end
    end

    // Launch one byte right after an edge; returns 1ns after the sampling edge
    task automatic send(input vec_t e);
        sbq.push_back(e);
        rxByte = e.b;
        rxDone = 1'b1;
        @(posedge clk);
        #1;
        rxDone = 1'b0;
    endtask

    task automatic pulses_low(input string nm);
        @(posedge clk);
        #1;
        n_tests++;
        if (restart !== 1'b0 || bad_key !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got restart=%b bad=%b, expected restart=0 bad=0", nm, restart, bad_key);
        end
    endtask

    // n consecutive cycles must all show the given steady outputs
    task automatic expect_hold(input string nm, input int n, input logic [3:0] d,
                               input logic [7:0] k, input logic p);
        bit         ok;
        int         at;
        logic [3:0] gd;
        logic [7:0] gk;
        logic       gp, gr, gb;
        ok = 1'b1; at = 0; gd = '0; gk = '0; gp = 1'b0; gr = 1'b0; gb = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ok && (dir !== d || key_out !== k || paused !== p ||
                       restart !== 1'b0 || bad_key !== 1'b0)) begin
                ok = 1'b0; at = i + 1;
                gd = dir; gk = key_out; gp = paused; gr = restart; gb = bad_key;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got dir=%b key=%h paused=%b restart=%b bad=%b, expected dir=%b key=%h paused=%b restart=0 bad=0",
                     nm, at, gd, gk, gp, gr, gb, d, k, p);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;

        //          id  byte   dir      key    p     rs    bk
        tbl[0]  = mk(0, 8'h77, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0); // w
        tbl[1]  = mk(1, 8'h57, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0); // W
        tbl[2]  = mk(2, 8'h64, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b0); // d
        tbl[3]  = mk(3, 8'h7A, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b1); // z
        tbl[4]  = mk(4, 8'h70, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0); // p
        tbl[5]  = mk(5, 8'h73, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0); // s paused
        tbl[6]  = mk(6, 8'h41, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0); // A paused
        tbl[7]  = mk(7, 8'h50, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0); // P
        tbl[8]  = mk(8, 8'h61, 4'b0010, 8'h61, 1'b0, 1'b0, 1'b0); // a
        tbl[9]  = mk(9, 8'h53, 4'b0100, 8'h73, 1'b0, 1'b0, 1'b0); // S
        tbl[10] = mk(10, 8'h72, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0); // r
        tbl[11] = mk(11, 8'h5B, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1); // [
        tbl[12] = mk(12, 8'h44, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b0); // D
        tbl[13] = mk(13, 8'h40, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b1); // @
        tbl[14] = mk(14, 8'h70, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0); // p
        tbl[15] = mk(15, 8'h52, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0); // R

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmp("after_reset_release", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        // Table of single-byte transactions
        for (int i = 0; i < 16; i++) begin
            send(tbl[i]);
            if (tbl[i].rs || tbl[i].bk) pulses_low($sformatf("pulse_len_vec%0d", i));
            repeat (2) @(posedge clk);
            #1;
        end

        // 'w' then release exactly 50 cycles after the output rose
        send(mk(100, 8'h77, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0));
        expect_hold("w_hold", 49, 4'b1000, 8'h77, 1'b0);
        @(posedge clk); #1;
        cmp("w_release", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        // 'd', 'D' 30 cycles later, release 50 cycles after 'D'
        send(mk(101, 8'h64, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b0));
        expect_hold("d_hold_pre", 29, 4'b0001, 8'h64, 1'b0);
        send(mk(102, 8'h44, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b0));
        expect_hold("d_hold_post", 49, 4'b0001, 8'h64, 1'b0);
        @(posedge clk); #1;
        cmp("d_release", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        // 'a' then 's' 10 cycles later: no gap between directions
        send(mk(103, 8'h61, 4'b0010, 8'h61, 1'b0, 1'b0, 1'b0));
        expect_hold("a_hold", 9, 4'b0010, 8'h61, 1'b0);
        send(mk(104, 8'h73, 4'b0100, 8'h73, 1'b0, 1'b0, 1'b0));
        expect_hold("s_hold", 49, 4'b0100, 8'h73, 1'b0);
        @(posedge clk); #1;
        cmp("s_release", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        // Back-to-back strobes on consecutive cycles
        send(mk(105, 8'h61, 4'b0010, 8'h61, 1'b0, 1'b0, 1'b0));
        send(mk(106, 8'h64, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b0));
        send(mk(107, 8'h7A, 4'b0001, 8'h64, 1'b0, 1'b0, 1'b1));
        expect_hold("b2b_hold", 48, 4'b0001, 8'h64, 1'b0);
        @(posedge clk); #1;
        cmp("b2b_release", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        // Pause while holding, direction ignored, unpause
        send(mk(108, 8'h77, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0));
        send(mk(109, 8'h70, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0));
        send(mk(110, 8'h73, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0));
        expect_hold("paused_steady", 3, 4'b0000, 8'h00, 1'b1);
        send(mk(111, 8'h50, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        // Restart while paused, then an unmapped byte
        send(mk(112, 8'h77, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0));
        send(mk(113, 8'h70, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0));
        send(mk(114, 8'h72, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0));
        pulses_low("restart_one_cycle");
        send(mk(115, 8'h7A, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1));
        pulses_low("bad_key_one_cycle");

        // Asynchronous reset mid-hold, no stale key afterwards
        send(mk(116, 8'h61, 4'b0010, 8'h61, 1'b0, 1'b0, 1'b0));
        k = int'($urandom_range(1, 40));
        repeat (k) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        cmp("async_reset_mid_hold", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        expect_hold("no_stale_key", 55, 4'b0000, 8'h00, 1'b0);

        // Direction byte on the expiry cycle keeps HELD and reloads
        send(mk(117, 8'h77, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0));
        expect_hold("expiry_pre", 49, 4'b1000, 8'h77, 1'b0);
        send(mk(118, 8'h77, 4'b1000, 8'h77, 1'b0, 1'b0, 1'b0));
        expect_hold("expiry_reload", 49, 4'b1000, 8'h77, 1'b0);
        @(posedge clk); #1;
        cmp("expiry_reload_release", mk(-1, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
